// File: rtl/fifo_write_pacer.sv
// Paced producer front-end for sync_fifo: buffers ready/valid words and replays them as
// write_en pulses spaced MIN_GAP clocks apart. Define FIFO_WRITE_PACER_FLUSH_EN to add a flush input.
module fifo_write_pacer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
`ifdef FIFO_WRITE_PACER_FLUSH_EN
  input  logic                         flush,
`endif
  output logic                         write_en,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t            state_reg, state_next;
  logic [GW-1:0]     gap_reg, gap_next;
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              write_en_reg;
  logic [WIDTH-1:0]  data_out_reg;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              flush_now;
  logic              have_word;
  logic              push;
  logic              pop;

`ifdef FIFO_WRITE_PACER_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // A flushing edge sees an empty buffer, so it never starts a new pulse.
  assign have_word = (count_reg != '0) && !flush_now;
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign push      = in_valid && in_ready && !flush_now;
  assign pop       = (state_next == EMIT);

  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: begin
        if (have_word) state_next = EMIT;
      end
      EMIT: begin
        if (MIN_GAP > 1) begin
          state_next = GAP;
          gap_next   = GW'(MIN_GAP - 1);
        end else begin
          state_next = have_word ? EMIT : IDLE;
        end
      end
      GAP: begin
        if (gap_reg <= GW'(1)) begin
          state_next = have_word ? EMIT : IDLE;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg - GW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gap_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      gap_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      write_en_reg <= 1'b0;
      data_out_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gap_reg      <= gap_next;
      write_en_reg <= pop;
      if (pop) data_out_reg <= mem[rd_ptr_reg[AW-1:0]];
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (flush_now) begin
        rd_ptr_reg <= wr_ptr_reg;
        count_reg  <= '0;
      end else begin
        if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= in_data;
  end

  assign write_en = write_en_reg;
  assign data_out = data_out_reg;
  assign count    = count_reg;
  assign idle     = (count_reg == '0) && (state_reg == IDLE);

endmodule

// File: tb/tb_fifo_write_pacer.sv
// Bench for fifo_write_pacer: two instances (MIN_GAP 8 and 1) checked every cycle against a
// queue-based timing model, plus directed tests with literal expectations.
`timescale 1ns/1ps
module tb_fifo_write_pacer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [31:0] in_data [2];
  logic [1:0]  flush;
  logic [1:0]  write_en;
  logic [31:0] data_out [2];
  logic [2:0]  count [2];
  logic [1:0]  idle;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int G = (gi == 0) ? 8 : 1;

    // Model: a word queue plus the time of the last pulse. A pulse fires at an edge when the
    // queue was non-empty before it and at least G edges have passed since the previous one.
    logic [31:0] mq [32];
    int          mh, mt, last_e, t;
    logic [31:0] exp_d;
    bit          exp_we;
    bit          rdy;

    fifo_write_pacer #(.WIDTH(32), .DEPTH(4), .MIN_GAP(G)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .in_data  (in_data[gi]),
`ifdef FIFO_WRITE_PACER_FLUSH_EN
      .flush    (flush[gi]),
`endif
      .write_en (write_en[gi]),
      .data_out (data_out[gi]),
      .count    (count[gi]),
      .idle     (idle[gi])
    );

    always @(posedge clk) begin
      t++;
      if (reset) begin
        mh = 0; mt = 0; last_e = -1000; exp_d = '0; exp_we = 0;
      end else begin
        rdy    = (mt - mh) != 4;
        exp_we = (mt != mh) && (t - last_e >= G) && !flush[gi];
        if (exp_we) begin
          exp_d  = mq[5'(mh)];
          mh++;
          last_e = t;
        end
        if (flush[gi]) mh = mt;
        else if (in_valid[gi] && rdy) begin
          mq[5'(mt)] = in_data[gi];
          mt++;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("u%0d_write_en", gi), 32'(write_en[gi]), 32'(exp_we));
      chk($sformatf("u%0d_data_out", gi), data_out[gi], exp_d);
      chk($sformatf("u%0d_count", gi), 32'(count[gi]), 32'(mt - mh));
      chk($sformatf("u%0d_in_ready", gi), 32'(in_ready[gi]), 32'((mt - mh) != 4));
      chk($sformatf("u%0d_idle", gi), 32'(idle[gi]), 32'((mt == mh) && (t - last_e >= G)));
      if (write_en[gi]) $display("u%0d t=%0d write data=%h", gi, t, data_out[gi]);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp;
    bit acc;
    bit saw_full;
    int k, np, guard, dens;

    reset = 1'b1; in_valid = '0; flush = '0;
    in_data[0] = '0; in_data[1] = '0;
    repeat (2) @(negedge clk);
    chk("reset_we", 32'(write_en[0]), 32'd0);
    chk("reset_data", data_out[0], 32'd0);
    chk("reset_count", 32'(count[0]), 32'd0);
    chk("reset_ready", 32'(in_ready[0]), 32'd1);
    chk("reset_idle", 32'(idle[1]), 32'd1);
    reset = 1'b0;

    // Single word: pulse exactly one cycle after the push edge, data held afterwards.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 32'hAABBCCDD;
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("single_we_N", 32'(write_en[0]), 32'd0);
    @(negedge clk);
    chk("single_we_N1", 32'(write_en[0]), 32'd1);
    chk("single_data_N1", data_out[0], 32'hAABBCCDD);
    @(negedge clk);
    chk("single_we_N2", 32'(write_en[0]), 32'd0);
    repeat (20) @(negedge clk);
    chk("single_hold", data_out[0], 32'hAABBCCDD);

    // Burst of 1..4 with MIN_GAP 8: pulses at N+1, N+9, N+17, N+25.
    for (int j = 0; j < 36; j++) begin
      if (j < 4) begin in_valid[0] = 1'b1; in_data[0] = j + 1; end
      else in_valid[0] = 1'b0;
      @(negedge clk);
      exp = (j >= 1) && ((j - 1) % 8 == 0) && (j <= 25);
      chk("burst_we", 32'(write_en[0]), 32'(exp));
      if (exp) chk("burst_data", data_out[0], (j - 1) / 8 + 1);
    end

    // Full and wrap: 11 words with valid held high.
    k = 0; np = 0; guard = 0; saw_full = 0;
    in_valid[0] = 1'b1; in_data[0] = 32'h100;
    while (k < 11 && guard < 400) begin
      acc = in_ready[0];
      if (count[0] == 3'd4 && !in_ready[0]) saw_full = 1;
      @(negedge clk);
      guard++;
      if (write_en[0]) begin chk("wrap_data", data_out[0], 32'h100 + np); np++; end
      if (acc) begin k++; in_data[0] = 32'h100 + k; end
    end
    in_valid[0] = 1'b0;
    chk("wrap_accepted", k, 32'd11);
    chk("wrap_saw_full", 32'(saw_full), 32'd1);
    for (int w = 0; w < 200 && np < 11; w++) begin
      @(negedge clk);
      if (write_en[0]) begin chk("wrap_data", data_out[0], 32'h100 + np); np++; end
    end
    chk("wrap_pulses", np, 32'd11);
    repeat (10) @(negedge clk);

    // MIN_GAP 1: three back-to-back pulses.
    for (int j = 0; j < 6; j++) begin
      if (j < 3) begin in_valid[1] = 1'b1; in_data[1] = 32'hC0DE0000 + j; end
      else in_valid[1] = 1'b0;
      @(negedge clk);
      exp = (j >= 1) && (j <= 3);
      chk("gap1_we", 32'(write_en[1]), 32'(exp));
      if (exp) chk("gap1_data", data_out[1], 32'hC0DE0000 + j - 1);
    end

    // Asynchronous reset mid-gap with two words queued.
    for (int j = 0; j < 5; j++) begin
      if (j < 3) begin in_valid[0] = 1'b1; in_data[0] = 32'hD0 + j; end
      else in_valid[0] = 1'b0;
      @(negedge clk);
    end
    chk("prereset_count", 32'(count[0]), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_we", 32'(write_en[0]), 32'd0);
    chk("async_data", data_out[0], 32'd0);
    chk("async_count", 32'(count[0]), 32'd0);
    chk("async_idle", 32'(idle[0]), 32'd1);
    chk("async_ready", 32'(in_ready[0]), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("postreset_we", 32'(write_en[0]), 32'd0);
    end

`ifdef FIFO_WRITE_PACER_FLUSH_EN
    // Flush during the first pulse; the word pushed on the flush edge is dropped.
    for (int j = 0; j < 25; j++) begin
      if (j < 3) begin in_valid[0] = 1'b1; in_data[0] = 32'hF0 + j; end
      else in_valid[0] = 1'b0;
      flush[0] = (j == 2);
      @(negedge clk);
      if (j == 1) begin
        chk("flush_we1", 32'(write_en[0]), 32'd1);
        chk("flush_data1", data_out[0], 32'hF0);
      end
      if (j >= 2) begin
        chk("flush_we", 32'(write_en[0]), 32'd0);
        chk("flush_count", 32'(count[0]), 32'd0);
        chk("flush_hold", data_out[0], 32'hF0);
      end
    end
    flush[0] = 1'b0;
`endif

    // Randomized traffic on both instances with shifting density.
    dens = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(5, 90);
      in_valid[0] = ($urandom_range(0, 99) < dens);
      in_valid[1] = ($urandom_range(0, 99) < dens);
      in_data[0]  = $urandom;
      in_data[1]  = $urandom;
      @(negedge clk);
    end
    in_valid = '0;
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
